// File: rtl/dlatch_ctrl_pkg.sv
// Shared types and helpers for the latch-bank write scheduler.
// Holds the write FSM state encoding and the phase-counter width helper.
package dlatch_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} wr_state_t;

  // Counter must hold the longest phase length minus one; +1 keeps a 1-cycle phase at width 1.
  function automatic int phase_cnt_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and the rotating pointer.
// The pointer moves past the winner only when the scheduler strobes advance.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_valid
);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] cand_idx;
  int unsigned   cand;

  // Scan from farthest to nearest offset so the first asserted index at/after ptr wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand     = (int'(ptr_reg) + i) % NREQ;
      cand_idx = PW'(cand);
      if (req[cand_idx]) begin
        grant_idx   = cand_idx;
        grant_valid = 1'b1;
      end
    end
    grant = grant_valid ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance) begin
      ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/dlatch_bank_wr_ctrl.sv
// Write scheduler for a bank of level-sensitive D latches on a shared data bus.
// Each write runs setup, enable-pulse and hold phases so D never moves while an enable is high.
module dlatch_bank_wr_ctrl
  import dlatch_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int NLATCH    = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 1,
  localparam int AW = (NLATCH > 1) ? $clog2(NLATCH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][AW-1:0]    req_addr,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            ack,
  output logic [WIDTH-1:0]           lat_D,
  output logic [NLATCH-1:0]          lat_en,
  output logic                       busy,
  output logic                       err
);

  localparam int CW = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wr_state_t         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [AW-1:0]     addr_reg, addr_next;
  logic              addr_ok_reg, addr_ok_next;
  logic [WIDTH-1:0]  lat_d_reg, lat_d_next;
  logic [NLATCH-1:0] lat_en_reg, lat_en_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;

  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     grant_idx;
  logic              grant_valid;
  logic              advance;
  logic              arb_point;
  logic [NLATCH-1:0] lat_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .advance     (advance),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  for (genvar gi = 0; gi < NLATCH; gi++) begin : g_sel
    assign lat_sel[gi] = (addr_reg == AW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    addr_ok_next = addr_ok_reg;
    lat_d_next   = lat_d_reg;
    lat_en_next  = lat_en_reg;
    ack_next     = '0;
    err_next     = 1'b0;
    advance      = 1'b0;
    arb_point    = 1'b0;

    unique case (state_reg)
      IDLE: arb_point = 1'b1;
      SETUP: begin
        if (cnt_reg == '0) begin
          state_next  = PULSE;
          cnt_next    = CW'(PULSE_CYC - 1);
          lat_en_next = addr_ok_reg ? lat_sel : '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          state_next  = HOLD;
          cnt_next    = CW'(HOLD_CYC - 1);
          lat_en_next = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == '0) begin
          arb_point = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // The only place lat_D changes: the edge that enters SETUP.
    if (arb_point) begin
      if (grant_valid) begin
        state_next   = SETUP;
        cnt_next     = CW'(SETUP_CYC - 1);
        addr_next    = req_addr[grant_idx];
        addr_ok_next = int'(req_addr[grant_idx]) < NLATCH;
        lat_d_next   = req_data[grant_idx];
        ack_next     = grant;
        err_next     = !(int'(req_addr[grant_idx]) < NLATCH);
        advance      = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      addr_reg    <= '0;
      addr_ok_reg <= 1'b0;
      lat_d_reg   <= '0;
      lat_en_reg  <= '0;
      ack_reg     <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      addr_ok_reg <= addr_ok_next;
      lat_d_reg   <= lat_d_next;
      lat_en_reg  <= lat_en_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
    end
  end

  assign ack    = ack_reg;
  assign lat_D  = lat_d_reg;
  assign lat_en = lat_en_reg;
  assign busy   = busy_reg;
  assign err    = err_reg;

  lat_d_stable_a: assert property (@(posedge clk) disable iff (rst)
    (|lat_en_reg) |=> $stable(lat_d_reg));

  lat_en_onehot_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0(lat_en_reg));

endmodule

// File: tb/tb_dlatch_bank_wr_ctrl.sv
// Bench for dlatch_bank_wr_ctrl: scoreboard of expected grants checked by a per-cycle monitor,
// plus scenario tasks with their own inline checks. A second instance has a 3-latch bank.
module tb_dlatch_bank_wr_ctrl;

  localparam int NREQ = 4, WIDTH = 8, NLATCH = 4, AW = 2;
  localparam int SETUP_CYC = 2, PULSE_CYC = 3, HOLD_CYC = 1;
  localparam int OCC = SETUP_CYC + PULSE_CYC + HOLD_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NREQ-1:0]            req = '0;
  logic [NREQ-1:0][AW-1:0]    req_addr = '0;
  logic [NREQ-1:0][WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]            ack;
  logic [WIDTH-1:0]           lat_D;
  logic [NLATCH-1:0]          lat_en;
  logic                       busy, err;

  logic [NREQ-1:0]            req3 = '0;
  logic [NREQ-1:0][1:0]       req_addr3 = '0;
  logic [NREQ-1:0][WIDTH-1:0] req_data3 = '0;
  logic [NREQ-1:0]            ack3;
  logic [WIDTH-1:0]           lat_D3;
  logic [2:0]                 lat_en3;
  logic                       busy3, err3;

  dlatch_bank_wr_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .NLATCH(NLATCH),
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .lat_D(lat_D), .lat_en(lat_en), .busy(busy), .err(err));

  dlatch_bank_wr_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .NLATCH(3),
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_addr(req_addr3), .req_data(req_data3),
    .ack(ack3), .lat_D(lat_D3), .lat_en(lat_en3), .busy(busy3), .err(err3));

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ack = 0;
  int   cyc   = 0;

  bit                active = 1'b0;
  int                r = 0;
  exp_t              cur;
  logic [NLATCH-1:0] exp_en;

  // Monitor: pops the scoreboard on each ack and checks the whole write window that follows.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
      r = 0;
    end else begin
      n_cmp++;
      if (!$onehot0(lat_en)) begin
        n_bad++;
        $display("FAIL onehot: lat_en=%b required at most one bit high", lat_en);
      end
      if (active) r++;
      if (ack != '0) begin
        n_ack++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ack: ack=%b with empty scoreboard", ack);
          active = 1'b0;
        end else begin
          cur = sb.pop_front();
          n_cmp++;
          if (ack !== (NREQ'(1) << cur.idx)) begin
            n_bad++;
            $display("FAIL ack_idx: ack=%b required %b", ack, NREQ'(1) << cur.idx);
          end
          if (active) begin
            n_cmp++;
            if (r != OCC) begin
              n_bad++;
              $display("FAIL occupancy: new ack %0d cycles after previous, required %0d", r, OCC);
            end
          end
          $display("txn: ack req %0d addr %0d data %02h", cur.idx, cur.addr, cur.data);
          active = 1'b1;
          r = 0;
          n_cmp++;
          if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_at_ack: err=%b required 0", err);
          end
        end
      end
      if (active) begin
        if (r < OCC) begin
          exp_en = '0;
          if (r >= SETUP_CYC && r < SETUP_CYC + PULSE_CYC) exp_en[cur.addr] = 1'b1;
          n_cmp++;
          if (lat_en !== exp_en) begin
            n_bad++;
            $display("FAIL lat_en_phase: r=%0d lat_en=%b required %b", r, lat_en, exp_en);
          end
          n_cmp++;
          if (lat_D !== cur.data) begin
            n_bad++;
            $display("FAIL lat_D_window: r=%0d lat_D=%02h required %02h", r, lat_D, cur.data);
          end
          n_cmp++;
          if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_high: r=%0d busy=%b required 1", r, busy);
          end
        end else begin
          n_cmp++;
          if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_low: busy=%b required 0 after write", busy);
          end
          active = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req3 = '0;
    sb.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk); #2;
      n++;
      if (!busy && !busy3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_cmp++;
    if ({ack, lat_en, lat_D, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ack=%b lat_en=%b lat_D=%02h busy=%b err=%b required all 0",
               ack, lat_en, lat_D, busy, err);
    end
    n_cmp++;
    if ({ack3, lat_en3, lat_D3, busy3, err3} !== '0) begin
      n_bad++;
      $display("FAIL reset_state3: ack=%b lat_en=%b lat_D=%02h busy=%b err=%b required all 0",
               ack3, lat_en3, lat_D3, busy3, err3);
    end
    $display("txn: reset checked");
  endtask

  task automatic test_single();
    exp_t e;
    bit ok;
    do_reset();
    repeat (2) @(negedge clk);
    #2;
    req_addr[1] = 2'd2;
    req_data[1] = 8'hA5;
    e.idx = 1; e.addr = 2'd2; e.data = 8'hA5;
    sb.push_back(e);
    req[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_latency: ack=%b one cycle after req, required 0010", ack);
    end
    #2 req[1] = 1'b0;
    wait_idle(20, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_idle: busy still %b after 20 cycles, required 0", busy);
    end
    n_cmp++;
    if (lat_D !== 8'hA5 || lat_en !== '0) begin
      n_bad++;
      $display("FAIL single_after: lat_D=%02h lat_en=%b required A5 and 0000", lat_D, lat_en);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    bit ok;
    int base, t0, budget;
    do_reset();
    base = n_ack;
    t0 = 0;
    budget = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = AW'(3 - i);
      req_data[i] = 8'(8'h30 + 8'(i * 17));
      e.idx = i; e.addr = req_addr[i]; e.data = req_data[i];
      sb.push_back(e);
    end
    req = 4'b1111;
    while (n_ack < base + 4 && budget < 100) begin
      @(negedge clk); #2;
      budget++;
      if (n_ack == base + 1 && t0 == 0) t0 = cyc;
      for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
    end
    n_cmp++;
    if (n_ack != base + 4) begin
      n_bad++;
      $display("FAIL contention_acks: %0d acks seen, required 4", n_ack - base);
    end
    n_cmp++;
    if (cyc - t0 != 3 * OCC) begin
      n_bad++;
      $display("FAIL contention_spacing: first to last ack %0d cycles, required %0d", cyc - t0, 3 * OCC);
    end
    req = '0;
    wait_idle(20, ok);
  endtask

  task automatic test_fairness();
    exp_t e;
    bit ok;
    int seen, g0, g2, budget;
    do_reset();
    seen = 0; g0 = 0; g2 = 0; budget = 0;
    req_addr[0] = 2'd3; req_data[0] = 8'h11;
    req_addr[2] = 2'd0; req_data[2] = 8'h22;
    e.idx = 0; e.addr = 2'd3; e.data = 8'h11; sb.push_back(e);
    e.idx = 2; e.addr = 2'd0; e.data = 8'h22; sb.push_back(e);
    req = 4'b0101;
    while (seen < 20 && budget < 400) begin
      @(negedge clk); #2;
      budget++;
      for (int i = 0; i < NREQ; i += 2) begin
        if (ack[i]) begin
          seen++;
          if (i == 0) g0++; else g2++;
          if (seen < 20) begin
            req_data[i] = 8'($urandom);
            req_addr[i] = AW'($urandom_range(0, NLATCH - 1));
            e.idx = i; e.addr = req_addr[i]; e.data = req_data[i];
            sb.push_back(e);
          end else begin
            req = '0;
          end
        end
      end
    end
    sb.delete();
    n_cmp++;
    if (g0 != 10 || g2 != 10) begin
      n_bad++;
      $display("FAIL fairness: grants req0=%0d req2=%0d required 10 each", g0, g2);
    end
    wait_idle(20, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL fairness_idle: busy=%b after drop, required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit ok, seen_en, first;
    int budget;
    do_reset();
    req_addr[1] = 2'd1; req_data[1] = 8'h3C;
    e.idx = 1; e.addr = 2'd1; e.data = 8'h3C; sb.push_back(e);
    req = 4'b0010;
    seen_en = 1'b0;
    budget = 0;
    while (!seen_en && budget < 20) begin
      @(negedge clk); #2;
      budget++;
      if (ack[1]) req[1] = 1'b0;
      if (lat_en != '0) seen_en = 1'b1;
    end
    n_cmp++;
    if (!seen_en) begin
      n_bad++;
      $display("FAIL async_pulse: lat_en never rose, required pulse before reset");
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (lat_en !== '0 || ack !== '0 || busy !== 1'b0 || lat_D !== '0) begin
      n_bad++;
      $display("FAIL async_reset: lat_en=%b ack=%b busy=%b lat_D=%02h required all 0 before clock",
               lat_en, ack, busy, lat_D);
    end
    sb.delete();
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    // Pointer was past requester 1; after reset requester 0 must win over 2.
    req_addr[0] = 2'd0; req_data[0] = 8'h77;
    req_addr[2] = 2'd2; req_data[2] = 8'h88;
    e.idx = 0; e.addr = 2'd0; e.data = 8'h77; sb.push_back(e);
    e.idx = 2; e.addr = 2'd2; e.data = 8'h88; sb.push_back(e);
    req = 4'b0101;
    first = 1'b1;
    budget = 0;
    while (req != '0 && budget < 40) begin
      @(negedge clk); #2;
      budget++;
      if (ack != '0 && first) begin
        first = 1'b0;
        n_cmp++;
        if (ack !== 4'b0001) begin
          n_bad++;
          $display("FAIL ptr_restart: first ack=%b after reset, required 0001", ack);
        end
      end
      for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
    end
    n_cmp++;
    if (req != '0) begin
      n_bad++;
      $display("FAIL ptr_restart_timeout: req=%b still pending, required 0000", req);
      req = '0;
    end
    wait_idle(20, ok);
  endtask

  task automatic test_out_of_range();
    int busy_cnt;
    do_reset();
    req_addr3[0] = 2'd3;
    req_data3[0] = 8'h5A;
    req3[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack3 !== 4'b0001 || err3 !== 1'b1 || lat_D3 !== 8'h5A) begin
      n_bad++;
      $display("FAIL oor_ack: ack=%b err=%b lat_D=%02h required 0001 1 5A", ack3, err3, lat_D3);
    end
    $display("txn: out-of-range write addr 3 on 3-latch bank");
    #2 req3[0] = 1'b0;
    busy_cnt = busy3 ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy3) busy_cnt++;
      n_cmp++;
      if (lat_en3 !== 3'b000 || err3 !== 1'b0) begin
        n_bad++;
        $display("FAIL oor_quiet: lat_en=%b err=%b required 000 0", lat_en3, err3);
      end
    end
    n_cmp++;
    if (busy_cnt != OCC) begin
      n_bad++;
      $display("FAIL oor_busy: busy high %0d cycles, required %0d", busy_cnt, OCC);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_async_reset();
    test_out_of_range();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
